// File: rtl/sc_hit_accumulator.sv
// Accumulates adder hit counts over a window of WINDOW valid samples and publishes a saturated total, a threshold flag and a done pulse.
// Latency: results and the done pulse appear one edge after the final valid sample is accepted.
// No backpressure: gaps in sumValid simply stall the window; start is ignored while busy.
module sc_hit_accumulator #(
    parameter int          SUM_WIDTH = 4,
    parameter int          ACC_WIDTH = 8,
    parameter int          WINDOW    = 16,
    parameter int          CNT_WIDTH = 8,
    parameter int unsigned THRESHOLD = 10
) (
    input  logic                 SC_HITACC_CLOCK_50,
    input  logic                 SC_HITACC_RESET_InLow,
    input  logic                 SC_HITACC_start_In,
    input  logic                 SC_HITACC_clear_In,
    input  logic [SUM_WIDTH-1:0] SC_HITACC_sum_In,
    input  logic                 SC_HITACC_sumValid_In,
    output logic [ACC_WIDTH-1:0] SC_HITACC_total_Out,
    output logic                 SC_HITACC_overThreshold_Out,
    output logic                 SC_HITACC_done_Out,
    output logic                 SC_HITACC_busy_Out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(WINDOW - 1);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX  = '1;

    state_t               state, stateNext;
    logic [ACC_WIDTH-1:0] acc, accNext;
    logic [CNT_WIDTH-1:0] cnt, cntNext;
    logic [ACC_WIDTH-1:0] totalNext;
    logic                 overNext;
    logic                 doneNext;
    logic [ACC_WIDTH:0]   accSum;
    logic [ACC_WIDTH-1:0] accSat;
    logic                 accOver;

    // One extra bit catches the carry so the add clamps instead of wrapping.
    assign accSum  = {1'b0, acc} + (ACC_WIDTH + 1)'(SC_HITACC_sum_In);
    assign accSat  = accSum[ACC_WIDTH] ? ACC_MAX : accSum[ACC_WIDTH-1:0];
    assign accOver = (32'(acc) >= THRESHOLD);

    assign SC_HITACC_busy_Out = (state != IDLE);

    always_comb begin
        stateNext = state;
        accNext   = acc;
        cntNext   = cnt;
        totalNext = SC_HITACC_total_Out;
        overNext  = SC_HITACC_overThreshold_Out;
        doneNext  = 1'b0;
        if (SC_HITACC_clear_In) begin
            stateNext = IDLE;
            accNext   = '0;
            cntNext   = '0;
            totalNext = '0;
            overNext  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (SC_HITACC_start_In) begin
                        accNext   = '0;
                        cntNext   = '0;
                        stateNext = ACCUM;
                    end
                end
                ACCUM: begin
                    if (SC_HITACC_sumValid_In) begin
                        accNext = accSat;
                        if (cnt == LAST_CNT) begin
                            stateNext = REPORT;
                        end else begin
                            cntNext = cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                REPORT: begin
                    totalNext = acc;
                    overNext  = accOver;
                    doneNext  = 1'b1;
                    stateNext = IDLE;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge SC_HITACC_CLOCK_50 or negedge SC_HITACC_RESET_InLow) begin
        if (!SC_HITACC_RESET_InLow) begin
            state                       <= IDLE;
            acc                         <= '0;
            cnt                         <= '0;
            SC_HITACC_total_Out         <= '0;
            SC_HITACC_overThreshold_Out <= 1'b0;
            SC_HITACC_done_Out          <= 1'b0;
        end else begin
            state                       <= stateNext;
            acc                         <= accNext;
            cnt                         <= cntNext;
            SC_HITACC_total_Out         <= totalNext;
            SC_HITACC_overThreshold_Out <= overNext;
            SC_HITACC_done_Out          <= doneNext;
        end
    end

endmodule

// File: tb/tb_sc_hit_accumulator.sv
// Directed bench for sc_hit_accumulator: default instance plus a 5-bit accumulator instance sharing stimulus.
// Expected window results are queued when the last sample is driven and checked when done pulses.
module tb_sc_hit_accumulator;

    typedef struct packed {
        logic [7:0] t8;
        logic       o8;
        logic [4:0] t5;
        logic       o5;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] sum = 4'd0;
    logic       sumValid = 1'b0;

    logic [7:0] total;
    logic       over, done, busy;
    logic [4:0] totalS;
    logic       overS, doneS, busyS;

    exp_t expQ[$];
    int   nVec = 0;
    int   nErr = 0;
    int   mAcc8, mAcc5, mCnt;
    logic [7:0] oldTotal;

    always #5 clk = ~clk;

    sc_hit_accumulator dut (
        .SC_HITACC_CLOCK_50         (clk),
        .SC_HITACC_RESET_InLow      (rstN),
        .SC_HITACC_start_In         (start),
        .SC_HITACC_clear_In         (clear),
        .SC_HITACC_sum_In           (sum),
        .SC_HITACC_sumValid_In      (sumValid),
        .SC_HITACC_total_Out        (total),
        .SC_HITACC_overThreshold_Out(over),
        .SC_HITACC_done_Out         (done),
        .SC_HITACC_busy_Out         (busy)
    );

    sc_hit_accumulator #(.ACC_WIDTH(5)) dutSat (
        .SC_HITACC_CLOCK_50         (clk),
        .SC_HITACC_RESET_InLow      (rstN),
        .SC_HITACC_start_In         (start),
        .SC_HITACC_clear_In         (clear),
        .SC_HITACC_sum_In           (sum),
        .SC_HITACC_sumValid_In      (sumValid),
        .SC_HITACC_total_Out        (totalS),
        .SC_HITACC_overThreshold_Out(overS),
        .SC_HITACC_done_Out         (doneS),
        .SC_HITACC_busy_Out         (busyS)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdleZero(input string tag);
        check({tag, "_total"}, {24'd0, total}, 32'd0);
        check({tag, "_over"}, {31'd0, over}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_totalSat"}, {27'd0, totalS}, 32'd0);
    endtask

    task automatic startWin();
        start = 1'b1;
        tick();
        start = 1'b0;
        mAcc8 = 0;
        mAcc5 = 0;
        mCnt  = 0;
        check("start_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic sample(input logic [3:0] s);
        exp_t e;
        sum      = s;
        sumValid = 1'b1;
        mAcc8 = (mAcc8 + int'(s) > 255) ? 255 : mAcc8 + int'(s);
        mAcc5 = (mAcc5 + int'(s) > 31) ? 31 : mAcc5 + int'(s);
        mCnt++;
        if (mCnt == 16) begin
            e.t8 = 8'(mAcc8);
            e.o8 = (mAcc8 >= 10);
            e.t5 = 5'(mAcc5);
            e.o5 = (mAcc5 >= 10);
            expQ.push_back(e);
        end
        tick();
        sumValid = 1'b0;
        sum      = 4'd0;
    endtask

    task automatic gap();
        sum      = 4'($urandom_range(0, 15));
        sumValid = 1'b0;
        tick();
        sum      = 4'd0;
    endtask

    // Leaves the bench in the cycle where done is high (if it arrives).
    task automatic waitDone(input string tag, input int expLat);
        int   n = 0;
        exp_t e;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, expLat);
        if (done === 1'b1 && expQ.size() > 0) begin
            e = expQ.pop_front();
            check({tag, "_total"}, {24'd0, total}, {24'd0, e.t8});
            check({tag, "_over"}, {31'd0, over}, {31'd0, e.o8});
            check({tag, "_totalSat"}, {27'd0, totalS}, {27'd0, e.t5});
            check({tag, "_overSat"}, {31'd0, overS}, {31'd0, e.o5});
            check({tag, "_doneSat"}, {31'd0, doneS}, 32'd1);
            check({tag, "_busyDone"}, {31'd0, busy}, 32'd0);
        end else begin
            check({tag, "_queued"}, {31'd0, done}, 32'd1);
        end
    endtask

    task automatic pulseEnds(input string tag);
        tick();
        check({tag, "_pulseWidth"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            start    = 1'($urandom_range(0, 1));
            clear    = 1'($urandom_range(0, 1));
            sum      = 4'($urandom_range(0, 15));
            sumValid = 1'($urandom_range(0, 1));
            tick();
            checkIdleZero("reset_held");
        end
        start = 1'b0; clear = 1'b0; sum = 4'd0; sumValid = 1'b0;
        rstN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sumValid = 1'($urandom_range(0, 1));
            sum      = 4'($urandom_range(0, 15));
            tick();
            if (i % 5 == 4) checkIdleZero("idle_no_start");
        end
        sumValid = 1'b0;

        // Full window of 4s: 64 on the 8-bit instance, 31 saturated on the 5-bit one
        startWin();
        for (int i = 0; i < 16; i++) begin
            sample(4'd4);
            check("full_busy", {31'd0, busy}, 32'd1);
            check("full_noEarlyDone", {31'd0, done}, 32'd0);
        end
        waitDone("full", 1);
        pulseEnds("full");

        // Gapped window hitting threshold exactly (10), then just under (9)
        for (int pass = 0; pass < 2; pass++) begin
            startWin();
            for (int i = 0; i < 16; i++) begin
                sample((i < 10 - pass) ? 4'd1 : 4'd0);
                if (i < 15) begin
                    gap();
                    check("gap_noEarlyDone", {31'd0, done}, 32'd0);
                end
            end
            waitDone(pass == 0 ? "gap_eq" : "gap_below", 1);
            pulseEnds("gap");
        end

        // start pulsed mid-window is ignored
        startWin();
        for (int i = 0; i < 16; i++) begin
            start = (i == 5 || i == 9);
            if (i == 9) gap();
            sample(4'(i % 4));
            start = 1'b0;
        end
        waitDone("midStart", 1);

        // Back-to-back: restart in the done cycle, old total holds meanwhile
        oldTotal = total;
        startWin();
        check("b2b_doneDropped", {31'd0, done}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            sample(4'd3);
            check("b2b_totalHeld", {24'd0, total}, {24'd0, oldTotal});
        end
        waitDone("b2b", 1);
        pulseEnds("b2b");

        // Synchronous clear after 7 samples aborts without done
        startWin();
        for (int i = 0; i < 7; i++) sample(4'd2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkIdleZero("clear");
        for (int i = 0; i < 20; i++) begin
            gap();
            check("clear_noDone", {31'd0, done}, 32'd0);
        end

        // Full window of 2s
        startWin();
        for (int i = 0; i < 16; i++) sample(4'd2);
        waitDone("twos", 1);
        pulseEnds("twos");

        // Asynchronous reset between edges after 7 samples
        startWin();
        for (int i = 0; i < 7; i++) sample(4'd2);
        #2 rstN = 1'b0;
        #1 checkIdleZero("asyncRst");
        tick();
        rstN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            gap();
            check("asyncRst_noDone", {31'd0, done}, 32'd0);
        end

        startWin();
        for (int i = 0; i < 16; i++) sample(4'd2);
        waitDone("twosAfterRst", 1);
        pulseEnds("twosAfterRst");

        check("queue_empty", expQ.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/sc_hit_accumulator.md
Name: sc_hit_accumulator

Overview:
- Downstream stage of the 4-input bit adder. It consumes the adder's per-frame hit count (0..4 active lanes) and accumulates it over a fixed window of valid samples.
- At the end of each window it publishes the window total, an over-threshold flag and a one-cycle done pulse.
- These outputs feed the game control logic, which uses them to decrement lives and raise speed level.

Parameters:
- SUM_WIDTH, 4, width of sum input; matches the adder output width.
- ACC_WIDTH, 8, width of accumulator and total output; saturating.
- WINDOW, 16, number of accepted samples per window; legal range 1..255.
- CNT_WIDTH, 8, width of the sample counter; must hold WINDOW-1.
- THRESHOLD, 10, total at or above which overThreshold is raised.

Ports:
- SC_HITACC_CLOCK_50  input  1  system clock, rising edge.
- SC_HITACC_RESET_InLow  input  1  asynchronous reset, active-low.
- SC_HITACC_start_In  input  1  start a new window; sampled in IDLE only.
- SC_HITACC_clear_In  input  1  synchronous clear, active-high.
- SC_HITACC_sum_In  input  SUM_WIDTH  hit count from the adder stage.
- SC_HITACC_sumValid_In  input  1  sum_In is valid this cycle.
- SC_HITACC_total_Out  output  ACC_WIDTH  latched window total.
- SC_HITACC_overThreshold_Out  output  1  latched: total >= THRESHOLD.
- SC_HITACC_done_Out  output  1  one-cycle pulse when the total is updated.
- SC_HITACC_busy_Out  output  1  high while state != IDLE.

Behaviour:
- Registers: state, acc, cnt, total_Out, overThreshold_Out, done_Out. busy_Out is decoded from state only (no input paths).
- Reset (RESET_InLow=0, asynchronous): state=IDLE; acc, cnt, total_Out, overThreshold_Out, done_Out all 0. busy_Out is therefore 0. Reset asserted mid-window aborts the window immediately; no done pulse is produced.
- Priority per edge: reset > clear_In > state logic.
- clear_In=1 has the same effect as reset, applied at the next edge.
- done_Out defaults to 0 every edge unless set by REPORT.
- IDLE:
  - start_In=1: acc<=0, cnt<=0, go to ACCUM.
  - total_Out and overThreshold_Out hold their previous values.
  - sumValid_In is ignored.
- ACCUM, edge with sumValid_In=1:
  - acc <= min(acc + zero-extended sum_In, 2^ACC_WIDTH-1). Saturating add: no wrap.
  - If cnt == WINDOW-1: go to REPORT. Otherwise cnt <= cnt+1.
- ACCUM, edge with sumValid_In=0: hold everything. Gaps of any length are allowed.
- start_In is ignored in ACCUM and REPORT; there is no restart while busy.
- REPORT (exactly one cycle): total_Out<=acc, overThreshold_Out<=(acc>=THRESHOLD), done_Out<=1, go to IDLE. sumValid_In is ignored in this cycle.
- Latency: the WINDOW-th valid sample is accepted at edge k. REPORT occupies cycle k..k+1. done_Out, total_Out and overThreshold_Out change at edge k+1 and are visible together in the first IDLE cycle. done_Out lasts exactly one cycle.
- Back-to-back windows: start_In=1 in the IDLE cycle where done_Out=1 is accepted. The new ACCUM starts at the next edge, and total_Out keeps the old result until the next REPORT.
- sum_In values above 4 are accumulated as given; no range check.
- The threshold comparison is unsigned and uses the saturated acc.
- WINDOW=1: one valid sample goes ACCUM->REPORT directly.

Test Plan:
- Reset: hold RESET_InLow=0 with random inputs -> all outputs 0. Release, no start for 20 cycles -> outputs stay 0, busy_Out=0.
- Full window, defaults: start, then 16 consecutive valid samples of 4 -> busy_Out=1 throughout. done_Out pulses once, one edge after REPORT. total_Out=64, overThreshold_Out=1, busy_Out=0 in the done cycle.
- Gapped and boundary: 16 valid samples, sumValid_In low every other cycle. Sums are ten 1s and six 0s -> total_Out=10, overThreshold_Out=1 (equals THRESHOLD). Repeat with nine 1s -> total_Out=9, overThreshold_Out=0. Verify done occurs only after the 16th valid sample.
- Saturation: ACC_WIDTH=5, 16 samples of 4 -> total_Out=31, no wrap, overThreshold_Out=1.
- Ignored/edge controls: start_In pulsed mid-ACCUM -> no effect, total after 16 samples is still correct. start_In in the done cycle -> second window begins and the old total holds until its done.
- Abort paths: clear_In after 7 samples -> next edge all outputs 0, IDLE, no done. Async reset after 7 samples (between edges) -> outputs 0 immediately. A following full window of 2s -> total_Out=32.
